// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Front-end conditioning for the board push-buttons. Each button is passed
//   through a 2-flop synchroniser, then debounced by its own four-state FSM
//   (IDLE, PRESS_CNT, HELD, REL_CNT) with a stability counter. The result is a
//   clean level plus single-cycle press and release pulses.
//   Bit order: 0=select, 1=right, 2=left, 3=up, 4=down.
//
// Optional feature (macro AUTO_REPEAT_EN):
//   When defined, buttons with REPEAT_MASK[i]=1 emit extra press pulses while
//   held: the first one REPEAT_DELAY cycles after the initial press pulse, then
//   one every REPEAT_PERIOD cycles. When undefined, no repeat logic exists and
//   the REPEAT_* parameters have no effect.
//
// Ports:
//   clk           in   1        system clock
//   rst_n         in   1        asynchronous, active-low reset
//   btn_in        in   NUM_BTN  raw, asynchronous, possibly bouncing inputs
//   btn_level     out  NUM_BTN  debounced level, 1 = held
//   btn_pressed   out  NUM_BTN  one-cycle pulse per accepted press (and repeat)
//   btn_released  out  NUM_BTN  one-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int                 NUM_BTN       = 5,
   parameter int                 DB_CYCLES     = 1000000,
   parameter int                 REPEAT_DELAY  = 50000000,
   parameter int                 REPEAT_PERIOD = 12500000,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK   = 5'b11000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pressed,
   output logic [NUM_BTN-1:0] btn_released
);

   localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_CNT,
      ST_HELD,
      ST_REL_CNT
   } state_t;

   // Reject configurations the counters cannot honour.
   if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("button_conditioner: DB_CYCLES must be >= 2 and REPEAT_* >= 1");
   end

   // Two-flop synchroniser; only r_sync2 is used downstream.
   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             r_pressed;
      logic             w_pressed_nxt;
      logic             r_released;
      logic             w_released_nxt;
      logic             w_rpt_fire;

`ifdef AUTO_REPEAT_EN
      if (REPEAT_MASK[i]) begin : g_rpt
         localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
         localparam int RPT_W   = $clog2(RPT_MAX + 1);

         logic [RPT_W-1:0] r_rpt_cnt;
         logic             r_rpt_first;   // next repeat uses REPEAT_DELAY
         logic             w_rpt_hit;

         assign w_rpt_hit  = (r_rpt_cnt == (r_rpt_first ? RPT_W'(REPEAT_DELAY - 1)
                                                         : RPT_W'(REPEAT_PERIOD - 1)));
         assign w_rpt_fire = (r_state == ST_HELD) && r_sync2[i] && w_rpt_hit;

         // Counts only while HELD with the button still down; REL_CNT (and the
         // HELD cycle that leaves for it) freezes the count so a release
         // glitch resumes where it left off. Any non-held state clears it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rpt_cnt   <= '0;
               r_rpt_first <= 1'b1;
            end else if (r_state == ST_HELD) begin
               if (r_sync2[i]) begin
                  if (w_rpt_hit) begin
                     r_rpt_cnt   <= '0;
                     r_rpt_first <= 1'b0;
                  end else begin
                     r_rpt_cnt <= r_rpt_cnt + 1'b1;
                  end
               end
            end else if (r_state != ST_REL_CNT) begin
               r_rpt_cnt   <= '0;
               r_rpt_first <= 1'b1;
            end
         end
      end else begin : g_no_rpt
         assign w_rpt_fire = 1'b0;
      end
`else
      assign w_rpt_fire = 1'b0;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
         end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pressed  <= w_pressed_nxt;
            r_released <= w_released_nxt;
         end
      end

      always_comb begin
         w_state_nxt    = r_state;
         w_cnt_nxt      = r_cnt;
         w_pressed_nxt  = 1'b0;
         w_released_nxt = 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_sync2[i]) begin
                  w_state_nxt = ST_PRESS_CNT;
                  w_cnt_nxt   = '0;
               end
            end
            ST_PRESS_CNT: begin
               if (!r_sync2[i]) begin
                  w_state_nxt = ST_IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  w_state_nxt   = ST_HELD;
                  w_pressed_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (!r_sync2[i]) begin
                  w_state_nxt = ST_REL_CNT;
                  w_cnt_nxt   = '0;
               end else if (w_rpt_fire) begin
                  w_pressed_nxt = 1'b1;
               end
            end
            ST_REL_CNT: begin
               if (r_sync2[i]) begin
                  w_state_nxt = ST_HELD;
               end else if (r_cnt == CNT_LAST) begin
                  w_state_nxt    = ST_IDLE;
                  w_released_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      // Level is a pure decode of the state register, so it moves on the
      // same edge as the press/release pulse.
      assign btn_level[i]    = (r_state == ST_HELD) || (r_state == ST_REL_CNT);
      assign btn_pressed[i]  = r_pressed;
      assign btn_released[i] = r_released;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DB_CYCLES=8, REPEAT_DELAY=40,
// REPEAT_PERIOD=10. Edge 0 is the edge just before an input change; the first
// edge sampling the new value is edge 1, and the pulse is visible after
// edge DB_CYCLES+3 = 11.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int NB = 5;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic [NB-1:0] btn_in = '0;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_pressed;
   logic [NB-1:0] btn_released;

   int n_chk  = 0;
   int n_pass = 0;
   int n_prs[NB];
   int n_rel[NB];
   logic both_seen = 1'b0;

   button_conditioner #(
      .NUM_BTN      (NB),
      .DB_CYCLES    (8),
      .REPEAT_DELAY (40),
      .REPEAT_PERIOD(10),
      .REPEAT_MASK  (5'b11000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_pressed (btn_pressed),
      .btn_released(btn_released)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic clr();
      for (int b = 0; b < NB; b++) begin
         n_prs[b] = 0;
         n_rel[b] = 0;
      end
   endtask

   // Advance n cycles, sampling 1 time unit after each rising edge.
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         for (int b = 0; b < NB; b++) begin
            n_prs[b] = n_prs[b] + int'(btn_pressed[b]);
            n_rel[b] = n_rel[b] + int'(btn_released[b]);
         end
         if ((btn_pressed & btn_released) != '0) both_seen = 1'b1;
      end
   endtask

   initial begin
      clr();
      #2 rst_n = 1'b0;
      run(3);
      check("rst_level",    32'(btn_level),    32'h0);
      check("rst_pressed",  32'(btn_pressed),  32'h0);
      check("rst_released", 32'(btn_released), 32'h0);
      rst_n = 1'b1;
      run(2);

      // Clean press on bit 3
      clr();
      btn_in = 5'b01000;
      run(10);
      check("press_early_cnt", n_prs[3], 0);
      check("press_early_lvl", 32'(btn_level), 32'h0);
      run(1);
      check("press_pulse", 32'(btn_pressed), 32'h08);
      check("press_level", 32'(btn_level),   32'h08);
      run(1);
      check("press_pulse_end", 32'(btn_pressed), 32'h0);
      check("press_once", n_prs[3], 1);
      check("press_others", n_prs[0] + n_prs[1] + n_prs[2] + n_prs[4], 0);

      // 5-cycle low glitch while held
      clr();
      btn_in = 5'b00000;
      run(5);
      btn_in = 5'b01000;
      run(30);
      check("relglitch_prs", n_prs[3], 0);
      check("relglitch_rel", n_rel[3], 0);
      check("relglitch_lvl", 32'(btn_level), 32'h08);

      // Clean release of bit 3
      clr();
      btn_in = 5'b00000;
      run(10);
      check("rel_early_cnt", n_rel[3], 0);
      check("rel_early_lvl", 32'(btn_level), 32'h08);
      run(1);
      check("rel_pulse", 32'(btn_released), 32'h08);
      check("rel_level", 32'(btn_level),    32'h0);
      run(1);
      check("rel_pulse_end", 32'(btn_released), 32'h0);

      // 7-cycle press glitch on bit 1
      clr();
      btn_in = 5'b00010;
      run(7);
      btn_in = 5'b00000;
      run(30);
      check("prsglitch_prs", n_prs[1], 0);
      check("prsglitch_rel", n_rel[1], 0);
      check("prsglitch_lvl", 32'(btn_level), 32'h0);

      // Bounce on bit 0: 3-cycle toggles for 30 cycles, then settle high
      clr();
      for (int seg = 0; seg < 10; seg++) begin
         btn_in = (seg % 2 == 0) ? 5'b00001 : 5'b00000;
         run(3);
      end
      btn_in = 5'b00001;
      run(10);
      check("bounce_early", n_prs[0], 0);
      run(1);
      check("bounce_pulse", 32'(btn_pressed), 32'h01);
      run(1);
      check("bounce_once", n_prs[0], 1);
      btn_in = 5'b00000;
      run(10);
      run(1);
      check("bounce_rel", 32'(btn_released), 32'h01);
      run(2);

      // Simultaneous press / release on bits 2 and 4
      clr();
      btn_in = 5'b10100;
      run(10);
      check("simul_early", n_prs[2] + n_prs[4], 0);
      run(1);
      check("simul_pulse", 32'(btn_pressed), 32'h14);
      btn_in = 5'b00000;
      run(10);
      check("simul_rel_early", n_rel[2] + n_rel[4], 0);
      run(1);
      check("simul_rel", 32'(btn_released), 32'h14);
      check("simul_rel_lvl", 32'(btn_level), 32'h0);
      run(2);

      // Reset while bit 3 is held
      clr();
      btn_in = 5'b01000;
      run(15);
      check("rstmid_held", 32'(btn_level), 32'h08);
      rst_n = 1'b0;
      #1;
      check("rstmid_async_lvl", 32'(btn_level), 32'h0);
      run(3);
      check("rstmid_no_rel", n_rel[3], 0);
      rst_n = 1'b1;
      clr();
      run(10);
      check("rstmid_early", n_prs[3], 0);
      run(1);
      check("rstmid_repress", 32'(btn_pressed), 32'h08);
      btn_in = 5'b00000;
      run(20);

`ifdef AUTO_REPEAT_EN
      // Auto-repeat on bit 4 (enabled) and bit 0 (masked)
      clr();
      btn_in = 5'b10000;
      run(11);
      check("rpt_first", 32'(btn_pressed), 32'h10);
      run(40);
      check("rpt_delay", 32'(btn_pressed), 32'h10);
      check("rpt_cnt2", n_prs[4], 2);
      run(10);
      check("rpt_cnt3", n_prs[4], 3);
      run(10);
      check("rpt_cnt4", n_prs[4], 4);
      run(29);
      check("rpt_cnt6", n_prs[4], 6);
      btn_in = 5'b00000;
      run(20);
      clr();
      btn_in = 5'b00001;
      run(100);
      check("rpt_masked", n_prs[0], 1);
      btn_in = 5'b00000;
      run(20);
`endif

      check("never_both", 32'(both_seen), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
